// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared widths, reset vector and op-priority decode for program_counter
package program_counter_pkg;

  localparam int          PC_WIDTH        = 16;
  localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_INC,
    OP_ADD,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } pc_op_e;

  // Fixed priority: call > ret > load > add > inc.
  function automatic pc_op_e pc_decode(input logic inc, input logic add, input logic load,
                                       input logic call, input logic ret);
    if (call)      return OP_CALL;
    else if (ret)  return OP_RET;
    else if (load) return OP_LOAD;
    else if (add)  return OP_ADD;
    else if (inc)  return OP_INC;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - ring-buffer return stack; PC_STACK_GUARD_EN selects guarded vs circular overflow
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign top_o   = mem_q[ptr_q - PTR_W'(1)];

`ifdef PC_STACK_GUARD_EN
  logic err_q, err_d;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign err_d   = err_q | (push_i & full_o) | (pop_i & empty_o);
  assign err_o   = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  // Full ring: the write slot is the oldest entry, so a push overwrites it.
  assign push_ok = push_i;
  assign pop_ok  = pop_i & ~empty_o;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_ok) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - bus-loadable PC with return stack; PC_STACK_GUARD_EN enables misuse guard
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] DATA,
  input  logic             enable,
  input  logic             inc,
  input  logic             add,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_value,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH-1:0] ret_addr;
  pc_op_e           op;
  logic             push, pop;

  assign op       = pc_decode(inc, add, load, call, ret);
  assign push     = (op == OP_CALL);
  assign pop      = (op == OP_RET);
  assign ret_addr = pc_q + WIDTH'(1);

  assign DATA     = enable ? pc_q : {WIDTH{1'bz}};
  assign pc_value = pc_q;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (ret_addr),
    .top_o       (stack_top),
    .empty_o     (stack_empty),
    .full_o      (stack_full),
    .err_o       (stack_err)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (op)
      OP_INC:  pc_d = pc_q + WIDTH'(1);
      OP_ADD:  pc_d = pc_q + DATA;
      OP_LOAD: pc_d = DATA;
      OP_CALL: begin
`ifdef PC_STACK_GUARD_EN
        if (!stack_full) pc_d = DATA;
`else
        pc_d = DATA;
`endif
      end
      OP_RET: begin
        if (!stack_empty) pc_d = stack_top;
`ifndef PC_STACK_GUARD_EN
        else              pc_d = RESET_VECTOR;
`endif
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed and random checks of program_counter against a queue-based model
module tb_program_counter;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0000;
`ifdef PC_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, inc, add, load, call, ret;
  logic [15:0] pc_value;
  logic        stack_empty, stack_full, stack_err;
  logic [15:0] tb_data;
  logic        tb_drv;
  wire  [15:0] data_bus;

  assign data_bus = tb_drv ? tb_data : 16'hzzzz;

  program_counter dut (
    .clk         (clk),
    .reset       (reset),
    .DATA        (data_bus),
    .enable      (enable),
    .inc         (inc),
    .add         (add),
    .load        (load),
    .call        (call),
    .ret         (ret),
    .pc_value    (pc_value),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_pc  = RV;
  logic [15:0] m_stk [$];
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: the stack is a list of return addresses, newest at the back.
  task automatic model(input bit r, c, rt, ld, ad, in, input logic [15:0] bus);
    if (r) begin
      m_pc = RV;
      m_stk.delete();
      m_err = 1'b0;
    end else if (c) begin
      if (m_stk.size() == DEPTH && GUARD) begin
        m_err = 1'b1;
      end else begin
        if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
        m_stk.push_back(m_pc + 16'd1);
        m_pc = bus;
      end
    end else if (rt) begin
      if (m_stk.size() == 0) begin
        if (GUARD) m_err = 1'b1;
        else       m_pc = RV;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (ld) m_pc = bus;
    else if (ad)     m_pc = m_pc + bus;
    else if (in)     m_pc = m_pc + 16'd1;
  endtask

  task automatic step(input string tag, input bit r, c, rt, ld, ad, in, en, input logic [15:0] d);
    logic [15:0] bus_seen;
    @(negedge clk);
    reset = r; call = c; ret = rt; load = ld; add = ad; inc = in;
    enable = en; tb_data = d; tb_drv = !en;
    bus_seen = en ? m_pc : d;
    @(posedge clk);
    model(r, c, rt, ld, ad, in, bus_seen);
    #1;
    chk({tag, "_pc"},    pc_value,           m_pc);
    chk({tag, "_empty"}, 16'(stack_empty),   16'(m_stk.size() == 0));
    chk({tag, "_full"},  16'(stack_full),    16'(m_stk.size() == DEPTH));
    chk({tag, "_err"},   16'(stack_err),     16'(m_err));
    chk({tag, "_bus"},   data_bus,           en ? m_pc : d);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; inc = 1'b0; add = 1'b0; load = 1'b0;
    call = 1'b0; ret = 1'b0; tb_data = 16'h0; tb_drv = 1'b1;

    step("rst", 1, 0, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_pc_const", pc_value, 16'h0000);
    chk("rst_empty_const", 16'(stack_empty), 16'h1);

    step("inc1", 0, 0, 0, 0, 0, 1, 0, 16'h0);
    step("inc2", 0, 0, 0, 0, 0, 1, 0, 16'h0);
    step("inc3", 0, 0, 0, 0, 0, 1, 0, 16'h0);
    chk("inc3_const", pc_value, 16'h0003);
    step("drive", 0, 0, 0, 0, 0, 0, 1, 16'h0);
    chk("drive_bus_const", data_bus, 16'h0003);
    step("release", 0, 0, 0, 0, 0, 0, 0, 16'hA5A5);

    step("ld10", 0, 0, 0, 1, 0, 0, 0, 16'h0010);
    step("add8", 0, 0, 0, 0, 1, 0, 0, 16'h0008);
    chk("add8_const", pc_value, 16'h0018);
    step("ldfffc", 0, 0, 0, 1, 0, 0, 0, 16'hFFFC);
    step("addwrap", 0, 0, 0, 0, 1, 0, 0, 16'h0008);
    chk("addwrap_const", pc_value, 16'h0004);

    step("ld20", 0, 0, 0, 1, 0, 0, 0, 16'h0020);
    step("call100", 0, 1, 0, 0, 0, 0, 0, 16'h0100);
    chk("call100_const", pc_value, 16'h0100);
    step("ret21", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("ret21_const", pc_value, 16'h0021);

    for (int i = 0; i < 5; i++)
      step($sformatf("nest%0d", i), 0, 1, 0, 0, 0, 0, 0, 16'h1000 + 16'(i * 16'h0100));
    for (int i = 0; i < 4; i++)
      step($sformatf("unnest%0d", i), 0, 0, 1, 0, 0, 0, 0, 16'h0);
    step("ret_empty", 0, 0, 1, 0, 0, 0, 0, 16'h0);

    step("ld5", 0, 0, 0, 1, 0, 0, 0, 16'h0005);
    step("prio", 0, 1, 0, 1, 0, 1, 0, 16'h0200);
    chk("prio_const", pc_value, 16'h0200);
    step("prio_ret", 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("prio_ret_const", pc_value, 16'h0006);

    step("callret_a", 0, 1, 0, 0, 0, 0, 0, 16'h0300);
    step("callret_b", 0, 0, 1, 0, 0, 0, 0, 16'h0);

    step("ld40", 0, 0, 0, 1, 0, 0, 0, 16'h0040);
    step("rst_call", 1, 1, 0, 0, 0, 0, 0, 16'h1234);
    chk("rst_call_const", pc_value, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'h0008 : 16'($urandom);
      step("rand",
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Bus-loadable 16-bit program counter with a small hardware return stack. It is the consumer of the shared 16-bit tri-state data bus: it loads absolute targets, adds bus-supplied offsets such as the constant ROM's stride value 8, and drives its own value back onto the same bus when enabled. It feeds the instruction-fetch address path and is sequenced by the control unit one operation per clock.

## Interface
- WIDTH, 16, PC and bus width.
- STACK_DEPTH, 4, return-stack entries; power of two, ≥2.
- RESET_VECTOR, 16'h0000, PC value after reset.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- DATA  inout  WIDTH  shared bus; driven with pc when enable=1, else high-Z; sampled by load/add/call.
- enable  input  1  drive pc onto DATA (combinational).
- inc  input  1  pc <= pc + 1.
- add  input  1  pc <= pc + DATA.
- load  input  1  pc <= DATA.
- call  input  1  push pc + 1, then pc <= DATA.
- ret  input  1  pc <= top of stack, pop.
- pc_value  output  WIDTH  current pc, always visible (fetch address).
- stack_empty  output  1  stack holds 0 entries.
- stack_full  output  1  stack holds STACK_DEPTH entries.
- stack_err  output  1  sticky misuse flag (see Configuration).

## Operation
- One operation per cycle. Fixed priority when several strobes are high: call > ret > load > add > inc. Lower-priority strobes are ignored that cycle. No strobe: pc holds.
- Arithmetic is modulo 2^WIDTH: 16'hFFFF + 1 = 16'h0000; carry discarded, no flag.
- add treats DATA as unsigned; a backward jump uses a two's-complement value on the bus.
- call: stack[sp] <= pc + 1 (wrapped), sp <= sp + 1, pc <= DATA; all in the same edge.
- ret: pc <= stack[sp-1], sp <= sp - 1.
- DATA is sampled as-is. With enable=1 and load/add/call in the same cycle, DATA equals pc: load is a no-op, add doubles pc, call jumps to itself. Legal; control unit never does this intentionally.
- DATA is driven only while enable=1; otherwise it is all Z, so other bus sources (constant ROM, registers) are unaffected.
- Reset values: pc = RESET_VECTOR, sp = 0, stack_empty = 1, stack_full = 0, stack_err = 0. Stack contents are not cleared; they are unreadable until written.
- Reset mid-operation: reset wins over all strobes in the same cycle; no push/pop occurs.

## Timing
- Strobes and DATA are sampled at rising edge N; pc_value/flags reflect the result after edge N (latency 1).
- DATA output: combinational from the pc register and enable; pc_value valid one edge after an update and is driven on the bus in that same cycle if enable=1.
- Back-to-back operations every cycle are supported, including call followed immediately by ret (returns to call-site + 1).
- stack_empty/stack_full are registered-state decodes of sp and update with the same edge as the push/pop.

## Configuration
- PC_STACK_GUARD_EN defined: call when stack_full, or ret when stack_empty, is ignored entirely (pc, sp, stack unchanged) and sets stack_err; stack_err clears only on reset.
- PC_STACK_GUARD_EN undefined: stack is circular. call when full overwrites the oldest entry, sp stays at depth, and stack_full stays 1. ret when empty sets pc <= RESET_VECTOR and leaves sp at 0. stack_err is tied to 0.

## Structure
- Shared package: WIDTH default, RESET_VECTOR, op-priority encoding (OP_NONE, OP_INC, OP_ADD, OP_LOAD, OP_CALL, OP_RET).
- One sub-module: return_stack (push/pop/top, sp, empty/full, guard/circular behaviour under the macro). Top level holds the pc register, priority decode, adder and tri-state driver.

## Test plan
- Reset, then inc ×3, then enable=1: pc_value 0→1→2→3; DATA = 16'h0003; enable=0 gives DATA all Z.
- Constant ROM drives 16'h0008, add asserted at pc=16'h0010: pc = 16'h0018; pc=16'hFFFC with add 8: pc = 16'h0004 (wrap).
- call with DATA=16'h0100 at pc=16'h0020, then ret: pc 16'h0100 then 16'h0021; stack_empty 1→0→1.
- Four nested calls then a fifth: stack_full=1; guard build keeps pc, sets stack_err; circular build jumps, and four rets then yield the last four return addresses.
- call, load, and inc all high with DATA=16'h0200 at pc=16'h0005: only call acts; pc = 16'h0200, top = 16'h0006.
- reset asserted with call pending at pc=16'h0040: pc = RESET_VECTOR, stack_empty=1, stack_err=0.
